// File: rtl/power_seq_pkg.sv
// Shared types and helpers for the power sequencing controller.
//   seq_state_e : controller state (IDLE, UP_STEP, DN_STEP)
//   lvl_width() : bits needed to hold a level count 0..num_domains
package power_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        UP_STEP = 2'd1,
        DN_STEP = 2'd2
    } seq_state_e;

    function automatic int lvl_width(input int num_domains);
        return $clog2(num_domains + 1);
    endfunction

endpackage

// File: rtl/power_seq_step_timer.sv
// Per-step settle timer: loads a delay on the start pulse and counts down to zero.
//   clock, resetn : clock, asynchronous active-low reset
//   start         : load load_val into the counter
//   load_val      : settle delay in cycles
//   done          : counter has reached zero
module power_seq_step_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_r;

    // Countdown register; saturates at zero so a maximum delay never wraps.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (start) begin
            cnt_r <= load_val;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/power_seq_ctrl.sv
// Power-domain sequencer. Brings domains up in order 0..N-1 (switch on, settle,
// release isolation) and down in order N-1..0 (isolate, settle, switch off).
//   clock, resetn : clock, asynchronous active-low reset
//   pwr_req       : 1 = all domains on, 0 = all domains off (level)
//   step_delay    : settle delay per step, sampled when a step starts
//   pwr_en        : power-switch enable per domain
//   iso_en        : isolation enable per domain
//   pwr_good      : all on, isolation released, idle
//   pwr_off       : all off, isolation asserted, idle
//   busy          : a step is in progress
module power_seq_ctrl
    import power_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int CNT_W       = 8
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   pwr_req,
    input  logic [CNT_W-1:0]       step_delay,
    output logic [NUM_DOMAINS-1:0] pwr_en,
    output logic [NUM_DOMAINS-1:0] iso_en,
    output logic                   pwr_good,
    output logic                   pwr_off,
    output logic                   busy
);

    localparam int               LVL_W   = lvl_width(NUM_DOMAINS);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_DOMAINS);
    localparam logic [LVL_W-1:0] LVL_MIN = {LVL_W{1'b0}};

    seq_state_e             state_r, state_s;
    logic [LVL_W-1:0]       lvl_r, lvl_s;
    logic [NUM_DOMAINS-1:0] pwr_en_r, pwr_en_s;
    logic [NUM_DOMAINS-1:0] iso_en_r, iso_en_s;
    logic                   pwr_good_r, pwr_off_r, busy_r;
    logic                   pwr_good_s, pwr_off_s, busy_s;
    logic                   start_s;
    logic                   done_s;
    logic [NUM_DOMAINS-1:0] up_mask_s;
    logic [NUM_DOMAINS-1:0] dn_mask_s;

    power_seq_step_timer #(
        .CNT_W (CNT_W)
    ) u_step_timer (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start_s),
        .load_val (step_delay),
        .done     (done_s)
    );

    // One-hot selects: next domain to power up, and the highest domain currently on.
    always_comb begin
        up_mask_s = NUM_DOMAINS'(1'b1) << lvl_r;
        dn_mask_s = NUM_DOMAINS'(1'b1) << (lvl_r - LVL_W'(1));
    end

    // Next-state logic; switch and isolation registers change in the order that
    // keeps every unpowered domain isolated.
    always_comb begin
        state_s  = state_r;
        lvl_s    = lvl_r;
        pwr_en_s = pwr_en_r;
        iso_en_s = iso_en_r;
        start_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (pwr_req && (lvl_r != LVL_MAX)) begin
                    state_s  = UP_STEP;
                    pwr_en_s = pwr_en_r | up_mask_s;
                    start_s  = 1'b1;
                end else if (!pwr_req && (lvl_r != LVL_MIN)) begin
                    state_s  = DN_STEP;
                    iso_en_s = iso_en_r | dn_mask_s;
                    start_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            UP_STEP: begin
                if (done_s) begin
                    iso_en_s = iso_en_r & ~up_mask_s;
                    lvl_s    = lvl_r + LVL_W'(1);
                    state_s  = IDLE;
                end else begin
                    state_s = UP_STEP;
                end
            end
            DN_STEP: begin
                if (done_s) begin
                    pwr_en_s = pwr_en_r & ~dn_mask_s;
                    lvl_s    = lvl_r - LVL_W'(1);
                    state_s  = IDLE;
                end else begin
                    state_s = DN_STEP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Status flags precomputed from next state so they come straight from flops.
    always_comb begin
        pwr_good_s = (state_s == IDLE) && (lvl_s == LVL_MAX);
        pwr_off_s  = (state_s == IDLE) && (lvl_s == LVL_MIN);
        busy_s     = (state_s != IDLE);
    end

    // State, level, domain controls and status registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            lvl_r      <= LVL_MIN;
            pwr_en_r   <= {NUM_DOMAINS{1'b0}};
            iso_en_r   <= {NUM_DOMAINS{1'b1}};
            pwr_good_r <= 1'b0;
            pwr_off_r  <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            lvl_r      <= lvl_s;
            pwr_en_r   <= pwr_en_s;
            iso_en_r   <= iso_en_s;
            pwr_good_r <= pwr_good_s;
            pwr_off_r  <= pwr_off_s;
            busy_r     <= busy_s;
        end
    end

    assign pwr_en   = pwr_en_r;
    assign iso_en   = iso_en_r;
    assign pwr_good = pwr_good_r;
    assign pwr_off  = pwr_off_r;
    assign busy     = busy_r;

endmodule

// File: doc/power_seq_ctrl.md
# power_seq_ctrl

Sequences NUM_DOMAINS power domains on and off in a fixed order, with a programmable settle delay per step. Power-up enables each domain's switch, waits, then releases its isolation. Power-down reverses both the order and the per-step actions. Sits between the power-management request source and the domain power-switch / isolation cells, alongside the power-logic delay chains.

## Interface
Parameters:
- NUM_DOMAINS, 4, number of sequenced domains (2..16); domain 0 powers up first and down last
- CNT_W, 8, width of the step delay counter

Ports:
- clock  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- pwr_req  in  1  level request: 1 = all domains on, 0 = all domains off
- step_delay  in  CNT_W  settle delay per step, in cycles; sampled at step start
- pwr_en  out  NUM_DOMAINS  power-switch enable per domain, active-high
- iso_en  out  NUM_DOMAINS  isolation enable per domain, active-high
- pwr_good  out  1  all domains on, isolation released, controller idle
- pwr_off  out  1  all domains off, isolation asserted, controller idle
- busy  out  1  a step is in progress

## Operation
- Level counter `lvl` (0..NUM_DOMAINS) = number of domains fully on.
- States: IDLE, UP_STEP, DN_STEP.
- IDLE:
  - pwr_req=1 and lvl<NUM_DOMAINS: enter UP_STEP, set pwr_en[lvl]=1, load cnt=step_delay.
  - pwr_req=0 and lvl>0: enter DN_STEP, set iso_en[lvl-1]=1, load cnt=step_delay.
  - Otherwise: remain in IDLE.
- UP_STEP:
  - cnt>0: decrement.
  - cnt==0: clear iso_en[lvl], lvl<=lvl+1, return to IDLE.
- DN_STEP:
  - cnt>0: decrement.
  - cnt==0: clear pwr_en[lvl-1], lvl<=lvl-1, return to IDLE.
- Steps are atomic. A pwr_req change mid-step has no effect until the step completes, and is evaluated in IDLE. This allows reversal at any domain boundary.
- Invariant: for every domain, iso_en=1 whenever pwr_en=0. A domain is never de-isolated while unpowered.
- step_delay changes mid-step have no effect on the current step.
- pwr_good = (state==IDLE && lvl==NUM_DOMAINS). pwr_off = (state==IDLE && lvl==0). busy = (state!=IDLE). All three are decoded from registers, glitch-free.

## Timing
- Reset values: pwr_en=0, iso_en=all 1s, lvl=0, state=IDLE, cnt=0, pwr_off=1, pwr_good=0, busy=0.
- Async reset mid-sequence forces the reset values immediately (abrupt off). The sequence restarts from lvl=0 after release.
- Step length: D=step_delay gives D+2 cycles per step (start edge, D decrement edges, completion edge). The next step starts one edge after completion.
- Power-up from pwr_req rising (sampled at edge 1):
  - pwr_en[k] rises at edge 1+k(D+2).
  - iso_en[k] falls at edge (k+1)(D+2).
  - pwr_good rises after edge NUM_DOMAINS*(D+2).
- Power-down is symmetric, in reverse domain order, with iso_en leading pwr_en.
- D=0 is legal: 2 cycles per step.
- D=2^CNT_W-1 is legal. No wrap: cnt only decrements when non-zero.

## Structure
- Package power_seq_pkg holds the state enum (IDLE, UP_STEP, DN_STEP) and the level width function $clog2(NUM_DOMAINS+1).
- Sub-module power_seq_step_timer: load / decrement / done counter of CNT_W bits. Loads on the start pulse; done when it reaches 0.
- Top holds the FSM, lvl, and the pwr_en/iso_en registers.

## Test plan
- Reset, then pwr_req=1, NUM_DOMAINS=4, D=3 -> pwr_en bits rise at edges 1,6,11,16; iso_en bits fall at 5,10,15,20; pwr_good=1 after edge 20.
- From ON, pwr_req=0, D=3 -> iso_en[3] rises at edge 1, pwr_en[3] falls at edge 5, …, domain 0 last; pwr_off=1 after edge 20.
- Drop pwr_req during domain 2 up-step (D=5) -> step completes (lvl=3), then down-steps run for domains 2,1,0 -> pwr_off=1.
- D=0 full up/down -> each step takes 2 cycles; invariant iso_en|pwr_en=1 holds every cycle (checked by assertion).
- Change step_delay from 3 to 10 mid-step -> current step keeps 5 cycles; next step takes 12.
- Assert resetn low while lvl=2 mid-step -> pwr_en=0 and iso_en=1111 immediately; after release with pwr_req=1, sequence restarts from domain 0.
